// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame geometry and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop1,
        StStop2
    } tx_state_e;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: emits a one-cycle tick on the last cycle of each CLKS_PER_BIT period.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic outclk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Clear holds the count at zero so the first period after release is full length.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == LastCnt) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge outclk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/enviar_serial.sv
// UART transmitter: 11-period frame (start, 8 data LSB first, two trailing high slots).
// Define ENVIAR_PARITY_EN to carry even parity in the first trailing slot.
module enviar_serial
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic       outclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       SalidaTx,
    output logic       tx_done
);

    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        line_q, line_d;
    logic        done_q, done_d;
    logic        tick;
    logic        accept;
    logic        stop1_level;

    assign tx_ready = (state_q == StIdle);
    assign accept   = tx_valid && tx_ready;
    assign SalidaTx = line_q;
    assign tx_done  = done_q;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .outclk(outclk),
        .reset (reset),
        .clear (state_q == StIdle),
        .tick  (tick)
    );

`ifdef ENVIAR_PARITY_EN
    logic parity_q;

    // Parity is captured with the byte so later tx_data changes cannot affect it.
    always_ff @(posedge outclk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= even_parity(tx_data);
        end
    end

    assign stop1_level = parity_q;
`else
    assign stop1_level = LINE_IDLE;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        line_d    = line_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                line_d = LINE_IDLE;
                if (accept) begin
                    shift_d   = tx_data;
                    bit_cnt_d = '0;
                    line_d    = LINE_START;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    line_d  = shift_q[0];
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        line_d  = stop1_level;
                        state_d = StStop1;
                    end else begin
                        line_d = shift_q[1];
                    end
                end
            end
            StStop1: begin
                if (tick) begin
                    line_d  = LINE_IDLE;
                    state_d = StStop2;
                end
            end
            StStop2: begin
                if (tick) begin
                    line_d  = LINE_IDLE;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                line_d  = LINE_IDLE;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge outclk) begin
        if (reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            line_q    <= LINE_IDLE;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            line_q    <= line_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: doc/enviar_serial.md
Name: enviar_serial

Overview:
- UART transmit stage directly upstream of the bit-clock receiver. Its serial output drives the receiver's EntradaTx input.
- Accepts one byte per valid/ready handshake and serialises it as an 11-period frame: start(0), 8 data bits LSB first, two trailing stop-slot periods (1,1).
- With CLKS_PER_BIT=1 the frame aligns one-to-one with the receiver's 11 states (0: start detect, 1–8: data, 9–10: trailing).

Parameters:
- CLKS_PER_BIT, 1, outclk cycles each bit period is held; legal range is 1 or more (1 is the receiver-matched rate).

Ports:
- outclk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- tx_data  in  8  byte to send; sampled only on the accept edge
- tx_valid  in  1  producer offers tx_data
- tx_ready  out  1  high only in IDLE; the accept edge is tx_valid && tx_ready
- SalidaTx  out  1  serial line, registered; idles high
- tx_done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset values: SalidaTx=1, tx_ready=1, tx_done=0, state=IDLE, counters=0, shift register=0.
- Reset asserted in any state aborts the frame:
  - SalidaTx is high on the next edge.
  - No tx_done is produced.
  - tx_valid is ignored while reset is high.
- States: IDLE, START, DATA, STOP1, STOP2.
- IDLE: SalidaTx=1.
  - On accept edge: load shift register with tx_data, clear bit counter (3 bit) and baud counter, go to START, drive SalidaTx=0 and tx_ready=0.
  - The line therefore goes low in the first cycle after the accept edge.
- Baud counter counts 0..CLKS_PER_BIT-1 in each bit state. The state advances on the edge where the count equals CLKS_PER_BIT-1, so each bit is held exactly CLKS_PER_BIT cycles.
- START to DATA: SalidaTx = shift[0].
- DATA: on each bit-period end, shift right and increment the bit counter. After bit 7 (counter==7), go to STOP1 with SalidaTx=1.
- STOP1 to STOP2: SalidaTx=1.
- STOP2 end: go to IDLE, set tx_ready=1, pulse tx_done=1 for exactly one cycle.
- Frame occupancy: 11*CLKS_PER_BIT cycles from the first low cycle.
  - The next accept can occur no earlier than the first IDLE cycle.
  - At least one idle-high cycle always separates frames, which gives the receiver a clean start detect.
- tx_valid while busy: ignored, tx_data not sampled, no back-pressure side effects.
- tx_data changes after the accept edge have no effect on the frame in flight.
- Bit counter and baud counter wrap only under state control; no other wrap is possible.

Optional Feature:
- Macro: ENVIAR_PARITY_EN.
- Defined:
  - The STOP1 slot carries even parity: XOR of the 8 data bits, computed at the accept edge.
  - Frame length is unchanged (11 periods). The receiver's trailing state 9 ignores this slot, so the link stays compatible.
- Undefined: STOP1 is high as described above, and no parity logic is synthesised.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE..STOP2)
  - FRAME_BITS=11 and DATA_BITS=8
  - the line idle level (1)
  - the start level (0)
- One natural sub-module, baud_tick_gen:
  - parameterised by CLKS_PER_BIT
  - inputs: outclk, reset, clear
  - output: a one-cycle tick at each bit-period end
  - used by enviar_serial; reused later by the receiver side.

Test Plan:
- CLKS_PER_BIT=1, send 0xA5. Required SalidaTx from the cycle after accept: 0,1,0,1,0,0,1,0,1,1,1, then high. tx_done pulses on the 11th edge after accept.
- Loopback into the receiver, CLKS_PER_BIT=1, send 0x3C then 0xFF. SalidaRx reads 0x3C, then 0xFF, with no spurious frame between them.
- CLKS_PER_BIT=4, send 0x81. Each bit is held exactly 4 cycles, and tx_ready is low for exactly 44 cycles.
- tx_valid held high with tx_data changing every cycle during a frame (0x11, 0x22, ...). Only the byte present at the accept edge is transmitted, and the next accept happens in the first IDLE cycle.
- reset pulsed during data bit 3 of 0x00. SalidaTx is high on the next edge, no tx_done, tx_ready=1 after reset deasserts, and the next frame is correct.
- ENVIAR_PARITY_EN defined:
  - 0x07 gives STOP1 slot = 1.
  - 0x03 gives STOP1 slot = 0.
  - STOP2 is always 1.
